pmem_responder: RTL and testbench

Synthesizable physical-memory responder for the cache-to-memory side of the mp2 system. It sits at the far end of the `pmem_*` bus and answers the cache's cacheline read and write requests. Requests are serviced with a fixed, parameterized latency from an internal line-wide storage array. It replaces the behavioural memory model in benches and FPGA builds, and flags protocol violations by the cache.

---
 rtl/pmem_responder.sv | 109 ++++++++++
 tb/tb_pmem_responder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pmem_responder.sv
// Fixed-latency cacheline memory for the pmem_* bus: services one read or write
// at a time from a line-wide array and flags cache protocol violations.
module pmem_responder #(
  parameter int DEPTH_LOG2 = 5,
  parameter int LATENCY    = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [15:0]  pmem_address,
  input  logic [127:0] pmem_wdata,
  output logic         pmem_resp,
  output logic [127:0] pmem_rdata,
  output logic         protocol_error
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam int         DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] LOAD  = 4'(LATENCY - 1);

  logic [127:0] mem [DEPTH];

  logic [1:0]   state;
  logic [3:0]   count;
  logic         cap_read;
  logic         cap_write;
  logic [15:0]  cap_addr;
  logic [127:0] cap_wdata;

  logic [DEPTH_LOG2-1:0] req_idx;
  logic [DEPTH_LOG2-1:0] cap_idx;
  logic                  req;
  logic                  req_changed;

  assign req_idx = pmem_address[3+DEPTH_LOG2:4];
  assign cap_idx = cap_addr[3+DEPTH_LOG2:4];
  assign req     = pmem_read | pmem_write;

  // The cache must hold strobes and address steady until it sees pmem_resp.
  assign req_changed = (pmem_read != cap_read) || (pmem_write != cap_write) ||
                       (pmem_address != cap_addr);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      count          <= 4'd0;
      cap_read       <= 1'b0;
      cap_write      <= 1'b0;
      cap_addr       <= 16'd0;
      cap_wdata      <= 128'd0;
      pmem_resp      <= 1'b0;
      pmem_rdata     <= 128'd0;
      protocol_error <= 1'b0;
    end else begin
      pmem_resp <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            cap_read  <= pmem_read;
            cap_write <= pmem_write;
            cap_addr  <= pmem_address;
            cap_wdata <= pmem_wdata;
            count     <= LOAD;
            if (pmem_read && pmem_write) protocol_error <= 1'b1;
            if (LATENCY == 1) begin
              state     <= RESP;
              pmem_resp <= 1'b1;
              if (!pmem_write) pmem_rdata <= mem[req_idx];
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (req_changed) begin
            state          <= IDLE;
            count          <= 4'd0;
            protocol_error <= 1'b1;
          end else begin
            count <= count - 4'd1;
            // Counter hits zero on this edge, so pmem_resp rises in cycle LATENCY.
            if (count == 4'd1) begin
              state     <= RESP;
              pmem_resp <= 1'b1;
              if (!cap_write) pmem_rdata <= mem[cap_idx];
            end
          end
        end
        RESP:    state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; a reset only suppresses
  // a pending commit so mid-transaction resets leave the line untouched.
  always_ff @(posedge clk) begin
    if (!rst && state == RESP && cap_write) mem[cap_idx] <= cap_wdata;
  end

endmodule

// File: tb/tb_pmem_responder.sv
// Scoreboard bench for pmem_responder: LATENCY=4 instance for the main scenarios,
// LATENCY=1 instance for the minimum-latency back-to-back case.
module tb_pmem_responder;

  logic         clk = 1'b0;
  logic         rst;
  logic         rd, wr, resp, err;
  logic [15:0]  addr;
  logic [127:0] wdata, rdata;
  logic         rd1, wr1, resp1, err1;
  logic [15:0]  addr1;
  logic [127:0] wdata1, rdata1;

  logic [127:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pmem_responder #(.DEPTH_LOG2(5), .LATENCY(4)) dut (
    .clk(clk), .rst(rst), .pmem_read(rd), .pmem_write(wr), .pmem_address(addr),
    .pmem_wdata(wdata), .pmem_resp(resp), .pmem_rdata(rdata), .protocol_error(err)
  );

  pmem_responder #(.DEPTH_LOG2(5), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .pmem_read(rd1), .pmem_write(wr1), .pmem_address(addr1),
    .pmem_wdata(wdata1), .pmem_resp(resp1), .pmem_rdata(rdata1), .protocol_error(err1)
  );

  // One cache transaction on the LATENCY=4 instance; cycle 0 is the first request cycle.
  task automatic txn(input logic r, input logic w, input logic [15:0] a,
                     input logic [127:0] wd, input logic [127:0] exp_rd,
                     input string name);
    int lat;
    logic [127:0] exp;
    @(posedge clk); #1;
    rd = r; wr = w; addr = a; wdata = wd;
    if (r && !w) exp_q.push_back(exp_rd);
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (resp) begin
        lat = k;
        break;
      end
    end
    rd = 1'b0; wr = 1'b0;
    checks++;
    if (lat !== 4) begin
      failures++;
      $display("FAIL %s_latency: resp cycle=%0d required=4 (-1 = timeout)", name, lat);
    end
    if (r && !w && exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      if (lat >= 0) begin
        checks++;
        if (rdata !== exp) begin
          failures++;
          $display("FAIL %s_rdata: got=%h required=%h", name, rdata, exp);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (resp !== 1'b0) begin
      failures++;
      $display("FAIL %s_resp_width: resp=%b in cycle after pulse, required 0", name, resp);
    end
  endtask

  task automatic watch_no_resp(input int n, input string name);
    int seen = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (resp) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL %s_no_resp: resp pulses=%0d required=0", name, seen);
    end
  endtask

  task automatic check_err(input logic exp, input string name);
    checks++;
    if (err !== exp) begin
      failures++;
      $display("FAIL %s: protocol_error=%b required=%b", name, err, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if ({resp, rdata, err} !== 130'd0 || {resp1, rdata1, err1} !== 130'd0) begin
        failures++;
        $display("FAIL reset_idle: cycle %0d resp=%b rdata=%h err=%b required all 0",
                 k, resp, rdata, err);
      end
    end
  endtask

  task automatic test_write_read();
    logic [127:0] d = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    txn(1'b0, 1'b1, 16'h0040, d, '0, "wr_0040");
    txn(1'b1, 1'b0, 16'h0040, '0, d, "rd_0040");
  endtask

  task automatic test_alias();
    logic [127:0] g = 128'hA5A5_0000_1111_2222_3333_4444_5555_6666;
    logic [127:0] a = 128'hDEAD_BEEF_CAFE_F00D_1234_5678_9ABC_DEF0;
    txn(1'b0, 1'b1, 16'h0020, g, '0, "wr_0020");
    txn(1'b0, 1'b1, 16'h0010, a, '0, "wr_0010");
    txn(1'b1, 1'b0, 16'h021F, '0, a, "rd_021f_alias");
    txn(1'b1, 1'b0, 16'h0020, '0, g, "rd_0020_neighbour");
  endtask

  task automatic test_dual_strobe();
    logic [127:0] b = 128'hB0B1_B2B3_B4B5_B6B7_B8B9_BABB_BCBD_BEBF;
    check_err(1'b0, "dual_err_before");
    txn(1'b1, 1'b1, 16'h0030, b, '0, "dual_0030");
    check_err(1'b1, "dual_err_set");
    txn(1'b1, 1'b0, 16'h0030, '0, b, "rd_0030_after_dual");
    check_err(1'b1, "dual_err_sticky");
  endtask

  task automatic test_reset_mid_op();
    logic [127:0] q = 128'h6060_6060_0000_0000_FFFF_FFFF_1234_4321;
    logic [127:0] e = 128'hEEEE_EEEE_EEEE_EEEE_EEEE_EEEE_EEEE_EEEE;
    txn(1'b0, 1'b1, 16'h0060, q, '0, "wr_0060_prior");
    @(posedge clk); #1;
    wr = 1'b1; addr = 16'h0060; wdata = e;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; wr = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    watch_no_resp(8, "reset_mid_op");
    check_err(1'b0, "reset_clears_err");
    txn(1'b1, 1'b0, 16'h0060, '0, q, "rd_0060_no_commit");
  endtask

  task automatic test_abort();
    logic [127:0] p = 128'h5050_5050_1357_9BDF_2468_ACE0_0F0F_F0F0;
    logic [127:0] c = 128'hCCCC_CCCC_CCCC_CCCC_CCCC_CCCC_CCCC_CCCC;
    txn(1'b0, 1'b1, 16'h0050, p, '0, "wr_0050_prior");
    check_err(1'b0, "abort_err_before");
    @(posedge clk); #1;
    wr = 1'b1; addr = 16'h0050; wdata = c;
    @(posedge clk); #1;
    @(posedge clk); #1;
    wr = 1'b0;
    watch_no_resp(8, "abort");
    check_err(1'b1, "abort_err_set");
    txn(1'b1, 1'b0, 16'h0050, '0, p, "rd_0050_after_abort");
  endtask

  task automatic test_back_to_back_lat1();
    logic [127:0] h = 128'h7777_1111_7777_2222_7777_3333_7777_4444;
    logic [7:0] exp_pat = 8'b1001_0010;  // bit k = resp expected in cycle k
    logic [127:0] exp;
    int lat;
    @(posedge clk); #1;
    wr1 = 1'b1; addr1 = 16'h0070; wdata1 = h;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (resp1 !== exp_pat[k]) begin
        failures++;
        $display("FAIL lat1_b2b_cycle%0d: resp=%b required=%b", k, resp1, exp_pat[k]);
      end
    end
    wr1 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rd1 = 1'b1; addr1 = 16'h0070;
    exp_q.push_back(h);
    lat = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (resp1) begin
        lat = k;
        break;
      end
    end
    rd1 = 1'b0;
    exp = exp_q.pop_front();
    checks++;
    if (lat !== 1) begin
      failures++;
      $display("FAIL lat1_rd_latency: resp cycle=%0d required=1 (-1 = timeout)", lat);
    end
    checks++;
    if (rdata1 !== exp) begin
      failures++;
      $display("FAIL lat1_rd_rdata: got=%h required=%h", rdata1, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0;
    test_reset();
    test_write_read();
    test_alias();
    test_dual_strobe();
    test_reset_mid_op();
    test_abort();
    test_back_to_back_lat1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
